ioctl_sdram_loader: RTL and testbench

IOCTL_SDRAM_LOADER -- requirements
Module: ioctl_sdram_loader

---
 rtl/ioctl_sdram_loader.sv | 153 +++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader.sv
// Streams HPS ioctl download words into SDRAM: one level request per word, held until ack.
// Optional running checksum over written words is enabled by defining IOCTL_LOADER_CSUM_EN.
module ioctl_sdram_loader #(
  parameter logic [7:0]  INDEX = 8'h00,
  parameter logic [24:0] BASE  = 25'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err_overrun,
  output logic [23:0] word_count,
  output logic [15:0] csum
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 24;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t        state, state_d;
  logic          match_c, match_q, rise_c, fall_c;
  logic          pend_done, pend_done_d;
  logic          mem_req_d, ioctl_wait_d, done_d, err_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_din_d;
  logic [CW-1:0] word_count_d;

  assign match_c = ioctl_download && (ioctl_index == INDEX);
  assign rise_c  = match_c && !match_q;
  assign fall_c  = !match_c && match_q;
  assign busy    = match_c || (state == S_REQ);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    mem_req_d    = mem_req;
    ioctl_wait_d = ioctl_wait;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    done_d       = 1'b0;
    err_d        = err_overrun;
    word_count_d = word_count;
    pend_done_d  = pend_done;

    if (rise_c) begin
      word_count_d = '0;
      err_d        = 1'b0;
      pend_done_d  = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (fall_c) begin
          done_d = 1'b1;
        end
        if (ioctl_wr && match_c) begin
          state_d      = S_REQ;
          mem_req_d    = 1'b1;
          ioctl_wait_d = 1'b1;
          mem_addr_d   = AW'(BASE + {ioctl_addr[AW-1:1], 1'b0});
          mem_din_d    = ioctl_dout;
        end
      end
      S_REQ: begin
        if (ioctl_wr) begin
          err_d = 1'b1;
        end
        // Session end during a pending write is reported once that write lands
        if (fall_c) begin
          pend_done_d = 1'b1;
        end
        if (mem_ack) begin
          state_d      = S_IDLE;
          mem_req_d    = 1'b0;
          ioctl_wait_d = 1'b0;
          if (word_count_d != '1) begin
            word_count_d = word_count_d + CW'(1);
          end
          done_d      = pend_done_d;
          pend_done_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      match_q     <= 1'b0;
      pend_done   <= 1'b0;
      mem_req     <= 1'b0;
      ioctl_wait  <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_d;
      match_q     <= match_c;
      pend_done   <= pend_done_d;
      mem_req     <= mem_req_d;
      ioctl_wait  <= ioctl_wait_d;
      mem_addr    <= mem_addr_d;
      mem_din     <= mem_din_d;
      done        <= done_d;
      err_overrun <= err_d;
      word_count  <= word_count_d;
    end
  end

`ifdef IOCTL_LOADER_CSUM_EN
  logic [DW-1:0] csum_d;

  // Checksum accumulates each completed word, cleared at session start
  always_comb begin
    csum_d = csum;
    if (rise_c) begin
      csum_d = '0;
    end
    if ((state == S_REQ) && mem_ack) begin
      csum_d = DW'(csum_d + mem_din);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      csum <= '0;
    end else begin
      csum <= csum_d;
    end
  end
`else
  assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: event-level model checked every cycle plus literal pins.
module tb_ioctl_sdram_loader;

  localparam logic [7:0]  INDEX = 8'h00;
  localparam logic [24:0] BASE  = 25'h1FFFFFE;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err_overrun;
  logic [23:0] word_count;
  logic [15:0] csum;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  ioctl_sdram_loader #(.INDEX(INDEX), .BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy), .done(done),
    .err_overrun(err_overrun), .word_count(word_count), .csum(csum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending write at most, tracked as session/transaction events
  logic        e_req, e_done, e_err, m_prev, p_done, m;
  logic [24:0] e_addr;
  logic [15:0] e_din, e_csum;
  logic [23:0] e_cnt;

  always @(posedge clk_sys) begin
    m = ioctl_download && (ioctl_index == INDEX);
    if (reset) begin
      e_req = 0; e_done = 0; e_err = 0; m_prev = 0; p_done = 0;
      e_addr = 0; e_din = 0; e_csum = 0; e_cnt = 0;
    end else begin
      e_done = 0;
      if (m && !m_prev) begin e_cnt = 0; e_err = 0; e_csum = 0; p_done = 0; end
      if (e_req) begin
        if (ioctl_wr) e_err = 1;
        if (!m && m_prev) p_done = 1;
        if (mem_ack) begin
          e_req = 0;
          if (e_cnt != 24'hFFFFFF) e_cnt = e_cnt + 24'd1;
          e_csum = e_csum + e_din;
          e_done = p_done;
          p_done = 0;
        end
      end else begin
        if (!m && m_prev) e_done = 1;
        if (ioctl_wr && m) begin
          e_req  = 1;
          e_addr = (BASE + {ioctl_addr[24:1], 1'b0}) % (1 << 25);
          e_din  = ioctl_dout;
        end
      end
      m_prev = m;
    end
  end

  always @(negedge clk_sys) begin
    if (run_cmp) begin
      chk("mem_req", mem_req, e_req);
      chk("ioctl_wait", ioctl_wait, e_req);
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_din", mem_din, e_din);
      end
      chk("done", done, e_done);
      chk("err_overrun", err_overrun, e_err);
      chk("word_count", word_count, e_cnt);
`ifdef IOCTL_LOADER_CSUM_EN
      chk("csum", csum, e_csum);
`else
      chk("csum", csum, 0);
`endif
      chk("busy", busy, (ioctl_download && ioctl_index == INDEX) || e_req);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int dly,
                          input logic [24:0] xa);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 0;
    chk("acc_req", mem_req, 1);
    chk("acc_wait", ioctl_wait, 1);
    chk("acc_addr", mem_addr, xa);
    chk("acc_din", mem_din, d);
    repeat (dly) tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("ack_clr_req", mem_req, 0);
    chk("ack_clr_wait", ioctl_wait, 0);
  endtask

  logic [15:0] x_csum;

  initial begin
    reset = 1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
    ioctl_addr = 0; ioctl_dout = 0; mem_ack = 0;
    tick();
    run_cmp = 1;
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_err", err_overrun, 0);
    reset = 0;
    tick();

    // Three-word session; addresses wrap through BASE
    ioctl_download = 1; ioctl_index = 8'h00;
    tick();
    do_write(25'd0, 16'h1234, 1, 25'h1FFFFFE);
    do_write(25'd2, 16'hABCD, 1, 25'h0000000);
    do_write(25'd4, 16'h0001, 1, 25'h0000002);
    ioctl_download = 0;
    tick();
    chk("s1_done", done, 1);
    chk("s1_cnt", word_count, 3);
`ifdef IOCTL_LOADER_CSUM_EN
    x_csum = 16'hBE02;
`else
    x_csum = 16'h0000;
`endif
    chk("s1_csum", csum, x_csum);
    tick();
    chk("s1_done_end", done, 0);

    // Non-matching index ignored
    ioctl_download = 1; ioctl_index = 8'h01;
    ioctl_wr = 1; ioctl_addr = 25'd6; ioctl_dout = 16'hDEAD;
    tick();
    ioctl_wr = 0;
    tick();
    chk("nm_req", mem_req, 0);
    chk("nm_wait", ioctl_wait, 0);
    chk("nm_cnt", word_count, 3);
    ioctl_download = 0;
    tick();

    // Overrun: second write one cycle after the first, late ack
    ioctl_download = 1; ioctl_index = 8'h00;
    tick();
    chk("s2_clr", word_count, 0);
    ioctl_wr = 1; ioctl_addr = 25'd8; ioctl_dout = 16'h5555;
    tick();
    chk("ov_addr", mem_addr, 25'h0000006);
    ioctl_addr = 25'd10; ioctl_dout = 16'h6666;
    tick();
    ioctl_wr = 0;
    chk("ov_err", err_overrun, 1);
    chk("ov_din", mem_din, 16'h5555);
    repeat (3) tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("ov_cnt", word_count, 1);
    chk("ov_req", mem_req, 0);

    // Ack in IDLE ignored
    mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    chk("idle_ack_cnt", word_count, 1);

    // Write and ack coincide in a fresh session
    ioctl_download = 0;
    tick();
    ioctl_download = 1;
    tick();
    chk("s3_err_clr", err_overrun, 0);
    ioctl_wr = 1; ioctl_addr = 25'd20; ioctl_dout = 16'h7777;
    tick();
    ioctl_wr = 0;
    tick();
    mem_ack = 1; ioctl_wr = 1; ioctl_dout = 16'h8888;
    tick();
    mem_ack = 0; ioctl_wr = 0;
    chk("co_err", err_overrun, 1);
    chk("co_cnt", word_count, 1);
    chk("co_req", mem_req, 0);
    tick();

    // Session ends during a pending write
    ioctl_download = 0;
    tick();
    ioctl_download = 1;
    tick();
    ioctl_wr = 1; ioctl_addr = 25'd12; ioctl_dout = 16'h4242;
    tick();
    ioctl_wr = 0; ioctl_download = 0;
    tick();
    chk("dr_busy", busy, 1);
    tick();
    tick();
    chk("dr_nodone", done, 0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("dr_done", done, 1);
    chk("dr_req", mem_req, 0);
    tick();
    chk("dr_done_end", done, 0);

    // Reset during a pending write
    ioctl_download = 1;
    tick();
    ioctl_wr = 1; ioctl_addr = 25'd14; ioctl_dout = 16'h9999;
    tick();
    ioctl_wr = 0;
    chk("rr_req_pre", mem_req, 1);
    reset = 1;
    tick();
    chk("rr_req", mem_req, 0);
    chk("rr_wait", ioctl_wait, 0);
    chk("rr_cnt", word_count, 0);
    reset = 0;
    tick();
    do_write(25'd16, 16'h1111, 0, 25'h000000E);
    chk("rr_cnt_after", word_count, 1);
    ioctl_download = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
